// File: rtl/imem_loader.sv
// Loads a framed, checksummed program image from a byte stream into the instruction memory.
// Each payload byte is written 1 cycle after acceptance; in_ready depends only on state, so upstream stalls freely.
// core_hold stays 1 until the image passes its length and checksum checks.
module imem_loader #(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err_len,
    output logic              err_csum
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   total;
    logic [7:0]        sum;

    logic              accept;
    logic [15:0]       len_full;
    logic [17:0]       len_bytes;
    logic [ADDR_W:0]   count_nxt;

    // Length is judged on the full 16-bit word count, widened so 4*N cannot wrap.
    always_comb begin
        accept    = in_valid && in_ready;
        len_full  = {in_byte, len_lo};
        len_bytes = {len_full, 2'b00};
        count_nxt = count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 8'h00;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err_len   <= 1'b0;
            err_csum  <= 1'b0;
            len_lo    <= 8'h00;
            count     <= '0;
            total     <= '0;
            sum       <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN_LO;
                        in_ready  <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        err_len   <= 1'b0;
                        err_csum  <= 1'b0;
                        count     <= '0;
                        sum       <= 8'h00;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_byte;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        if (len_full == 16'h0000 || len_bytes > MEM_LIMIT) begin
                            state    <= ERR;
                            err_len  <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            total <= len_bytes[ADDR_W:0];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= count[ADDR_W-1:0];
                        mem_wdata <= in_byte;
                        count     <= count_nxt;
                        sum       <= sum + in_byte;
                        if (count_nxt == total) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_byte == sum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state    <= ERR;
                            err_csum <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames checked against a frame-level model of the loader.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       core_hold;
    logic       done;
    logic       err_len;
    logic       err_csum;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:31];
    logic [12:0] got [$];
    logic [7:0]  pay_src [$];

    imem_loader #(.MEM_BYTES(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .err_len   (err_len),
        .err_csum  (err_csum)
    );

    always #5 clk = ~clk;

    // Memory-side observer: the instruction array as the fetch path would see it.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got.push_back({mem_waddr, mem_wdata});
            mem[mem_waddr] = mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        int waited;
        gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_byte  = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input int gapmax, input bit bad,
                             input bit do_start, input bit mid_start);
        logic [7:0] pay [$];
        logic [7:0] b;
        logic [7:0] csum;
        bit         len_ok;
        bit         ok;
        int         nbytes;
        len_ok = (n != 16'd0) && (int'(n) * 4 <= 32);
        nbytes = len_ok ? int'(n) * 4 : 0;
        ok     = len_ok && !bad;
        csum   = 8'h00;
        got.delete();
        if (do_start) pulse_start();
        send_byte(n[7:0], gapmax);
        send_byte(n[15:8], gapmax);
        if (len_ok) begin
            for (int k = 0; k < nbytes; k++) begin
                b = (pay_src.size() > k) ? pay_src[k] : 8'($urandom);
                pay.push_back(b);
                csum = csum + b;
                send_byte(b, gapmax);
                chk("wr_latency_we", 32'(mem_we), 32'd1);
                chk("wr_latency_addr", 32'(mem_waddr), 32'(k));
                chk("wr_latency_data", 32'(mem_wdata), 32'(b));
                if (mid_start && k == 2) pulse_start();
            end
            send_byte(bad ? csum + 8'd1 : csum, gapmax);
        end
        repeat (2) @(negedge clk);
        chk("done", 32'(done), 32'(ok));
        chk("err_len", 32'(err_len), 32'(!len_ok));
        chk("err_csum", 32'(err_csum), 32'(len_ok && bad));
        chk("core_hold", 32'(core_hold), 32'(!ok));
        chk("in_ready_end", 32'(in_ready), 32'd0);
        chk("write_count", 32'(got.size()), 32'(nbytes));
        for (int k = 0; k < nbytes && k < got.size(); k++) begin
            chk("write_addr", 32'(got[k][12:8]), 32'(k));
            chk("write_data", 32'(got[k][7:0]), 32'(pay[k]));
            chk("mem_byte", 32'(mem[k]), 32'(pay[k]));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        chk("rst_err_csum", 32'(err_csum), 32'd0);
        reset = 1'b0;

        // Idle loader must ignore offered bytes.
        got.delete();
        in_valid = 1'b1;
        in_byte = 8'h77;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_writes", 32'(got.size()), 32'd0);

        // Known program: two RISC-V words.
        pay_src = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF};
        run_frame(16'd2, 0, 1'b0, 1'b1, 1'b0);
        chk("imem_pc0", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500113);
        chk("imem_pc4", {mem[7], mem[6], mem[5], mem[4]}, 32'hFFC4A303);
        run_frame(16'd2, 0, 1'b1, 1'b1, 1'b0);
        pay_src.delete();

        // Length errors, including counts that only fit if truncated.
        run_frame(16'd9, 0, 1'b0, 1'b1, 1'b0);
        run_frame(16'd0, 1, 1'b0, 1'b1, 1'b0);
        run_frame(16'h4001, 0, 1'b0, 1'b1, 1'b0);
        run_frame(16'h0101, 0, 1'b0, 1'b1, 1'b0);

        // Full memory with stalls.
        run_frame(16'd8, 3, 1'b0, 1'b1, 1'b0);
        if (got.size() == 32) chk("last_addr", 32'(got[31][12:8]), 32'd31);

        // Reset in the middle of the payload.
        got.delete();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k), 0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_byte = 8'h55;
        @(negedge clk);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_hold", 32'(core_hold), 32'd1);
        chk("midrst_waddr", 32'(mem_waddr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_writes", 32'(got.size()), 32'd4);
        chk("midrst_idle_ready", 32'(in_ready), 32'd0);
        run_frame(16'd2, 1, 1'b0, 1'b1, 1'b0);

        // start during DATA is ignored; start in DONE restarts.
        run_frame(16'd2, 1, 1'b0, 1'b1, 1'b1);
        pulse_start();
        chk("restart_hold", 32'(core_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);
        run_frame(16'd3, 1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_frame(16'($urandom_range(1, 8)), 2, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
